pwm_hbridge_bank: RTL

//  Parametrised bank of NOS_CHANNELS PWM/H-bridge drivers sharing one period counter. Generalises
//  the single pwm_channel. Adds double-buffered duty/period/mode, 4-mode H-bridge control and

---
 rtl/pwm_hbridge_bank_if.sv | 32 +++
 rtl/pwm_hbridge_bank.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_hbridge_bank_if.sv
// Register-bus interface for the PWM/H-bridge bank.
// The master drives strobes, address and write data; the slave returns a
// registered acknowledge and read data (zero when not acknowledging, so
// several slaves can be OR-ed onto one bus).
interface pwm_hbridge_bank_if #(
    parameter int ADDR_BITS = 8
);
    logic                 reg_wr;
    logic                 reg_rd;
    logic [ADDR_BITS-1:0] reg_addr;
    logic [31:0]          reg_wdata;
    logic [31:0]          reg_rdata;
    logic                 reg_ack;

    modport master (
        output reg_wr,
        output reg_rd,
        output reg_addr,
        output reg_wdata,
        input  reg_rdata,
        input  reg_ack
    );

    modport slave (
        input  reg_wr,
        input  reg_rd,
        input  reg_addr,
        input  reg_wdata,
        output reg_rdata,
        output reg_ack
    );
endinterface

// File: rtl/pwm_hbridge_bank.sv
// Bank of PWM/H-bridge channels sharing one period counter.
// PERIOD, DUTY and mode are double-buffered: bus writes land in shadow
// registers and are copied to the active set at each period wrap (or on a
// force_sync).  Switching a channel directly between two driven modes
// (forward/reverse/brake) blanks both bridge legs for DEADTIME cycles so the
// two legs of the bridge are never switched through each other.
module pwm_hbridge_bank #(
    parameter int                   NOS_CHANNELS  = 4,
    parameter int                   PWM_BITS      = 16,
    parameter int                   DEADTIME_BITS = 8,
    parameter int                   ADDR_BITS     = 8,
    parameter logic [ADDR_BITS-1:0] BASE_ADDR     = 8'h10
) (
    input  logic                    clk,
    input  logic                    reset,
    pwm_hbridge_bank_if.slave       bus,
    output logic [NOS_CHANNELS-1:0] pwm_out,
    output logic [NOS_CHANNELS-1:0] H_bridge_1,
    output logic [NOS_CHANNELS-1:0] H_bridge_2,
    output logic                    period_tick
);

    // Highest register offset used by the bank.
    localparam int LAST_OFF = 3 + 2 * NOS_CHANNELS;

    localparam logic [1:0] MODE_COAST   = 2'b00;
    localparam logic [1:0] MODE_FORWARD = 2'b01;
    localparam logic [1:0] MODE_REVERSE = 2'b10;
    localparam logic [1:0] MODE_BRAKE   = 2'b11;

    // Leg drive {H1, H2} for a mode and raw PWM level; only brake drives both.
    function automatic logic [1:0] bridge_legs(input logic [1:0] mode, input logic pwm);
        logic [1:0] legs;
        case (mode)
            MODE_COAST:   legs = 2'b00;
            MODE_FORWARD: legs = {pwm, 1'b0};
            MODE_REVERSE: legs = {1'b0, pwm};
            MODE_BRAKE:   legs = 2'b11;
            default:      legs = 2'b00;
        endcase
        return legs;
    endfunction

    // Register state
    logic                     enable_q, enable_d;
    logic [PWM_BITS-1:0]      period_shadow_q, period_shadow_d;
    logic [PWM_BITS-1:0]      period_active_q, period_active_d;
    logic [DEADTIME_BITS-1:0] deadtime_q, deadtime_d;
    logic [PWM_BITS-1:0]      count_q, count_d;
    logic [PWM_BITS-1:0]      duty_shadow_q [NOS_CHANNELS];
    logic [PWM_BITS-1:0]      duty_shadow_d [NOS_CHANNELS];
    logic [PWM_BITS-1:0]      duty_active_q [NOS_CHANNELS];
    logic [PWM_BITS-1:0]      duty_active_d [NOS_CHANNELS];
    logic [1:0]               mode_shadow_q [NOS_CHANNELS];
    logic [1:0]               mode_shadow_d [NOS_CHANNELS];
    logic [1:0]               mode_active_q [NOS_CHANNELS];
    logic [1:0]               mode_active_d [NOS_CHANNELS];
    logic [DEADTIME_BITS-1:0] dt_cnt_q [NOS_CHANNELS];
    logic [DEADTIME_BITS-1:0] dt_cnt_d [NOS_CHANNELS];

    // Registered outputs
    logic [NOS_CHANNELS-1:0]  pwm_q, pwm_d;
    logic [NOS_CHANNELS-1:0]  h1_q, h1_d;
    logic [NOS_CHANNELS-1:0]  h2_q, h2_d;
    logic                     tick_q, tick_d;
    logic                     ack_q, ack_d;
    logic [31:0]              rdata_q, rdata_d;

    // Decode and control helpers
    logic [ADDR_BITS-1:0]     addr_off_s;
    logic                     in_range_s;
    logic                     wr_hit_s;
    logic                     rd_hit_s;
    logic                     sync_s;
    logic                     load_s;
    logic [1:0]               legs_s;
    logic                     unused_wdata_s;

    // Upper write-data bits are only partly consumed depending on the register.
    assign unused_wdata_s = ^bus.reg_wdata;

    // Address decode: the bank answers only inside its own window.
    always_comb begin
        addr_off_s = bus.reg_addr - BASE_ADDR;
        in_range_s = (bus.reg_addr >= BASE_ADDR) && (addr_off_s <= ADDR_BITS'(LAST_OFF));
        wr_hit_s   = bus.reg_wr & in_range_s;
        rd_hit_s   = bus.reg_rd & in_range_s;
    end

    // Next-state logic: bus access, period counter, shadow load, dead-time and outputs.
    always_comb begin
        enable_d        = enable_q;
        period_shadow_d = period_shadow_q;
        period_active_d = period_active_q;
        deadtime_d      = deadtime_q;
        count_d         = count_q;
        duty_shadow_d   = duty_shadow_q;
        duty_active_d   = duty_active_q;
        mode_shadow_d   = mode_shadow_q;
        mode_active_d   = mode_active_q;
        dt_cnt_d        = dt_cnt_q;
        pwm_d           = '0;
        h1_d            = '0;
        h2_d            = '0;
        tick_d          = 1'b0;
        ack_d           = wr_hit_s | rd_hit_s;
        rdata_d         = 32'd0;
        sync_s          = 1'b0;
        load_s          = 1'b0;
        legs_s          = 2'b00;

        // Bus access; a simultaneous read and write is treated as a write only.
        if (wr_hit_s) begin
            case (addr_off_s)
                ADDR_BITS'(0): begin
                    enable_d = bus.reg_wdata[0];
                    sync_s   = bus.reg_wdata[1];
                end
                ADDR_BITS'(1): period_shadow_d = bus.reg_wdata[PWM_BITS-1:0];
                ADDR_BITS'(2): deadtime_d      = bus.reg_wdata[DEADTIME_BITS-1:0];
                ADDR_BITS'(3): sync_s          = 1'b0;  // COUNT is read-only
                default: begin
                    for (int n = 0; n < NOS_CHANNELS; n++) begin
                        if (addr_off_s == ADDR_BITS'(4 + 2 * n)) begin
                            duty_shadow_d[n] = bus.reg_wdata[PWM_BITS-1:0];
                        end else if (addr_off_s == ADDR_BITS'(5 + 2 * n)) begin
                            mode_shadow_d[n] = bus.reg_wdata[1:0];
                        end else begin
                            mode_shadow_d[n] = mode_shadow_d[n];
                        end
                    end
                end
            endcase
        end else if (rd_hit_s) begin
            case (addr_off_s)
                ADDR_BITS'(0): rdata_d = {31'd0, enable_q};
                ADDR_BITS'(1): rdata_d = 32'(period_shadow_q);
                ADDR_BITS'(2): rdata_d = 32'(deadtime_q);
                ADDR_BITS'(3): rdata_d = 32'(count_q);
                default: begin
                    for (int n = 0; n < NOS_CHANNELS; n++) begin
                        if (addr_off_s == ADDR_BITS'(4 + 2 * n)) begin
                            rdata_d = 32'(duty_shadow_q[n]);
                        end else if (addr_off_s == ADDR_BITS'(5 + 2 * n)) begin
                            rdata_d = 32'(mode_shadow_q[n]);
                        end else begin
                            rdata_d = rdata_d;
                        end
                    end
                end
            endcase
        end else begin
            rdata_d = 32'd0;
        end

        // Shared period counter; force_sync restarts the period and loads shadows at once.
        if (sync_s) begin
            count_d = '0;
            load_s  = 1'b1;
        end else if (!enable_q) begin
            count_d = '0;
        end else if (count_q == period_active_q) begin
            count_d = '0;
            tick_d  = 1'b1;
            load_s  = 1'b1;
        end else begin
            count_d = count_q + PWM_BITS'(1);
        end

        if (load_s) begin
            period_active_d = period_shadow_q;
        end else begin
            period_active_d = period_active_q;
        end

        for (int n = 0; n < NOS_CHANNELS; n++) begin
            // Boundary copy of the per-channel shadows.
            if (load_s) begin
                duty_active_d[n] = duty_shadow_q[n];
                mode_active_d[n] = mode_shadow_q[n];
            end else begin
                duty_active_d[n] = duty_active_q[n];
                mode_active_d[n] = mode_active_q[n];
            end

            // Dead-time only between two distinct driven modes; coast edges are gap-free.
            if (load_s && (mode_shadow_q[n] != mode_active_q[n])) begin
                if ((mode_shadow_q[n] != MODE_COAST) && (mode_active_q[n] != MODE_COAST)) begin
                    dt_cnt_d[n] = deadtime_q;
                end else begin
                    dt_cnt_d[n] = '0;
                end
            end else if (dt_cnt_q[n] != '0) begin
                dt_cnt_d[n] = dt_cnt_q[n] - DEADTIME_BITS'(1);
            end else begin
                dt_cnt_d[n] = '0;
            end

            pwm_d[n] = enable_q & (count_q < duty_active_q[n]);
            if (!enable_q || (dt_cnt_q[n] != '0)) begin
                legs_s = 2'b00;
            end else begin
                legs_s = bridge_legs(mode_active_q[n], pwm_d[n]);
            end
            h1_d[n] = legs_s[1];
            h2_d[n] = legs_s[0];
        end
    end

    // State and output registers; asynchronous reset returns to coast with outputs low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q        <= 1'b0;
            period_shadow_q <= '0;
            period_active_q <= '0;
            deadtime_q      <= '0;
            count_q         <= '0;
            for (int n = 0; n < NOS_CHANNELS; n++) begin
                duty_shadow_q[n] <= '0;
                duty_active_q[n] <= '0;
                mode_shadow_q[n] <= MODE_COAST;
                mode_active_q[n] <= MODE_COAST;
                dt_cnt_q[n]      <= '0;
            end
            pwm_q   <= '0;
            h1_q    <= '0;
            h2_q    <= '0;
            tick_q  <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            enable_q        <= enable_d;
            period_shadow_q <= period_shadow_d;
            period_active_q <= period_active_d;
            deadtime_q      <= deadtime_d;
            count_q         <= count_d;
            for (int n = 0; n < NOS_CHANNELS; n++) begin
                duty_shadow_q[n] <= duty_shadow_d[n];
                duty_active_q[n] <= duty_active_d[n];
                mode_shadow_q[n] <= mode_shadow_d[n];
                mode_active_q[n] <= mode_active_d[n];
                dt_cnt_q[n]      <= dt_cnt_d[n];
            end
            pwm_q   <= pwm_d;
            h1_q    <= h1_d;
            h2_q    <= h2_d;
            tick_q  <= tick_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    assign pwm_out       = pwm_q;
    assign H_bridge_1    = h1_q;
    assign H_bridge_2    = h2_q;
    assign period_tick   = tick_q;
    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;

endmodule
